timcou_multi: RTL and testbench

Parametrised multi-channel timer/counter peripheral on the MIPS device bus: NCH independent down-counters, each with a control, preset, count and status word. Each channel adds a per-channel prescaler, a sticky write-1-to-clear interrupt status, and a maskable OR-combined interrupt line. It replaces the single-channel timer in the bridge's device slot and keeps the same bus handshake.

---
 rtl/timcou_multi.sv | 207 ++++++++++++++++++++
 tb/tb_timcou_multi.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timcou_multi.sv
// timcou_multi -- multi-channel timer/counter on the MIPS device bus.
//
// NCH independent down-counters. Each channel has a prescaler, a sticky
// write-1-to-clear pending flag and an interrupt mask. The masked flags are
// OR-combined onto intrp.
//
// Parameters:
//   NCH  channel count (1..8)
//   CW   counter/preset width (8..32); zero-extended on read, truncated on write
//   PSW  prescaler field width (1..8)
//
// Ports:
//   clk       system clock; all state changes on the rising edge
//   reset     asynchronous, active-low; clears every register
//   DEV_Addr  byte address: [3:2] register select, [6:4] channel select
//   DEV_WE    write strobe, one cycle per write
//   DEV_WD    write data
//   DEV_RD    read data, combinational from DEV_Addr
//   intrp     OR over channels of (PEND & IM)
//
// Bus handshake: there is no ready/valid back-pressure. A write completes at
// the clk edge where DEV_WE=1. A read returns the pre-edge register value in
// the same cycle.
//
// Per-channel register map (base = ch*16):
//   +0 CTRL    [0] EN, [2:1] MODE, [3] IM, [4] CASC, [8+PSW-1:8] PS
//   +4 PRESET  read/write
//   +8 COUNT   read-only
//   +C STATUS  [0] PEND, write 1 to clear
// A channel select of NCH or higher ignores writes and reads 32'h66666666.
//
// Optional feature macro: TIMCOU_CASCADE_EN. When it is defined, channels
// 1..NCH-1 implement CTRL[4] (CASC). With CASC=1, the channel ticks on the
// previous channel's COUNT 1->0 transition instead of on its own prescaler.
// When the macro is not defined, CTRL[4] always reads 0.
module timcou_multi #(
    parameter int NCH = 2,
    parameter int CW  = 32,
    parameter int PSW = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] DEV_Addr,
    input  logic        DEV_WE,
    input  logic [31:0] DEV_WD,
    output logic [31:0] DEV_RD,
    output logic        intrp
);

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_PRESET = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    logic [NCH-1:0] r_en;
    logic [NCH-1:0] r_im;
    logic [NCH-1:0] r_pend;
    logic [1:0]     r_mode  [NCH];
    logic [PSW-1:0] r_ps    [NCH];
    logic [PSW-1:0] r_pscnt [NCH];
    logic [CW-1:0]  r_preset[NCH];
    logic [CW-1:0]  r_count [NCH];
`ifdef TIMCOU_CASCADE_EN
    logic [NCH-1:0] r_casc;
`endif

    logic [2:0]     w_ch;
    logic [1:0]     w_reg;
    logic [NCH-1:0] w_wr_ch;    // any write to this channel
    logic [NCH-1:0] w_wr_ctrl;
    logic [NCH-1:0] w_wr_stat;
    logic [NCH-1:0] w_tick;     // tick source active this cycle
    logic [NCH-1:0] w_act;      // tick action taken (not overridden by a write)
    logic [NCH-1:0] w_fire;     // COUNT 1->0 this cycle
    logic           w_unused;

    assign w_ch     = DEV_Addr[6:4];
    assign w_reg    = DEV_Addr[3:2];
    assign w_unused = ^{DEV_Addr[31:7], DEV_Addr[1:0], DEV_WD};

    always_comb begin
`ifdef TIMCOU_CASCADE_EN
        logic v_prev_fire;
        v_prev_fire = 1'b0;
`endif
        w_wr_ch   = '0;
        w_wr_ctrl = '0;
        w_wr_stat = '0;
        w_tick    = '0;
        w_act     = '0;
        w_fire    = '0;
        for (int c = 0; c < NCH; c++) begin
            w_wr_ch[c]   = DEV_WE && (w_ch == 3'(c));
            w_wr_ctrl[c] = w_wr_ch[c] && (w_reg == REG_CTRL);
            w_wr_stat[c] = w_wr_ch[c] && (w_reg == REG_STATUS);
            // MODE=1x freezes the channel entirely.
            w_tick[c]    = r_en[c] && !r_mode[c][1] && (r_pscnt[c] == r_ps[c]);
`ifdef TIMCOU_CASCADE_EN
            // The cascade source is evaluated in channel order, so channel
            // c sees channel c-1's fire from the same cycle.
            if (r_casc[c]) begin
                w_tick[c] = r_en[c] && !r_mode[c][1] && v_prev_fire;
            end
`endif
            // Any bus write to the channel overrides its tick action.
            w_act[c]  = w_tick[c] && !w_wr_ch[c];
            w_fire[c] = w_act[c] && (r_count[c] == CW'(1));
`ifdef TIMCOU_CASCADE_EN
            v_prev_fire = w_fire[c];
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_en   <= '0;
            r_im   <= '0;
            r_pend <= '0;
`ifdef TIMCOU_CASCADE_EN
            r_casc <= '0;
`endif
            for (int c = 0; c < NCH; c++) begin
                r_mode[c]   <= '0;
                r_ps[c]     <= '0;
                r_pscnt[c]  <= '0;
                r_preset[c] <= '0;
                r_count[c]  <= '0;
            end
        end else begin
            for (int c = 0; c < NCH; c++) begin
                // Prescaler: a CTRL write restarts the phase. The prescaler is
                // held at zero while EN=0 and frozen in MODE=1x.
                if (w_wr_ctrl[c] || !r_en[c]) begin
                    r_pscnt[c] <= '0;
`ifdef TIMCOU_CASCADE_EN
                end else if (r_casc[c]) begin
                    r_pscnt[c] <= '0;
`endif
                end else if (!r_mode[c][1]) begin
                    r_pscnt[c] <= (r_pscnt[c] == r_ps[c]) ? '0 : r_pscnt[c] + 1'b1;
                end

                // Bus writes
                if (w_wr_ctrl[c]) begin
                    r_en[c]   <= DEV_WD[0];
                    r_mode[c] <= DEV_WD[2:1];
                    r_im[c]   <= DEV_WD[3];
                    r_ps[c]   <= DEV_WD[8 +: PSW];
`ifdef TIMCOU_CASCADE_EN
                    r_casc[c] <= (c != 0) ? DEV_WD[4] : 1'b0;
`endif
                end
                if (w_wr_ch[c] && (w_reg == REG_PRESET)) begin
                    r_preset[c] <= DEV_WD[CW-1:0];
                end
                if (w_wr_stat[c] && DEV_WD[0]) begin
                    r_pend[c] <= 1'b0;
                end

                // Tick action. It never coincides with a write to the same
                // channel. PEND set sits last so that a set beats a clear.
                if (w_act[c]) begin
                    if (r_count[c] > CW'(1)) begin
                        r_count[c] <= r_count[c] - 1'b1;
                    end else if (r_count[c] == CW'(1)) begin
                        r_count[c] <= '0;
                        if (r_mode[c] == 2'b00) begin
                            r_en[c] <= 1'b0;
                        end
                    end else begin
                        r_count[c] <= r_preset[c];
                    end
                end
                if (w_fire[c]) begin
                    r_pend[c] <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        logic [31:0] v_ctrl;
        v_ctrl = '0;
        DEV_RD = 32'h6666_6666;
        for (int c = 0; c < NCH; c++) begin
            if (w_ch == 3'(c)) begin
                v_ctrl          = '0;
                v_ctrl[0]       = r_en[c];
                v_ctrl[2:1]     = r_mode[c];
                v_ctrl[3]       = r_im[c];
`ifdef TIMCOU_CASCADE_EN
                v_ctrl[4]       = r_casc[c];
`endif
                v_ctrl[8 +: PSW] = r_ps[c];
                case (w_reg)
                    REG_CTRL:   DEV_RD = v_ctrl;
                    REG_PRESET: DEV_RD = 32'(r_preset[c]);
                    REG_COUNT:  DEV_RD = 32'(r_count[c]);
                    default:    DEV_RD = {31'b0, r_pend[c]};
                endcase
            end
        end
    end

    assign intrp = |(r_pend & r_im);

endmodule

// File: tb/tb_timcou_multi.sv
// Self-checking bench for timcou_multi. A behavioural channel model
// (integer state, plain arithmetic) predicts every read and intrp.
module tb_timcou_multi;

  localparam int NCH = 2;
  localparam int CW  = 16;
  localparam int PSW = 4;
  localparam logic [31:0] CW_MASK = (32'h1 << CW) - 1;
`ifdef TIMCOU_CASCADE_EN
  localparam bit CASC_ON = 1'b1;
`else
  localparam bit CASC_ON = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [31:0] DEV_Addr;
  logic        DEV_WE;
  logic [31:0] DEV_WD;
  logic [31:0] DEV_RD;
  logic        intrp;

  int n_cmp;
  int n_err;

  timcou_multi #(.NCH(NCH), .CW(CW), .PSW(PSW)) dut (
    .clk      (clk),
    .reset    (reset),
    .DEV_Addr (DEV_Addr),
    .DEV_WE   (DEV_WE),
    .DEV_WD   (DEV_WD),
    .DEV_RD   (DEV_RD),
    .intrp    (intrp)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int m_en[NCH], m_mode[NCH], m_im[NCH], m_casc[NCH], m_ps[NCH];
  int m_phase[NCH];          // clocks since the prescaler phase restarted
  int m_preset[NCH], m_count[NCH], m_pend[NCH];

  function automatic void model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_en[c] = 0; m_mode[c] = 0; m_im[c] = 0; m_casc[c] = 0; m_ps[c] = 0;
      m_phase[c] = 0; m_preset[c] = 0; m_count[c] = 0; m_pend[c] = 0;
    end
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    int sel;
    int rg;
    sel = int'(a[6:4]);
    rg  = int'(a[3:2]);
    if (sel >= NCH) return 32'h6666_6666;
    case (rg)
      0: return 32'(m_en[sel] + 2 * m_mode[sel] + 8 * m_im[sel] + 16 * m_casc[sel] + 256 * m_ps[sel]);
      1: return 32'(m_preset[sel]);
      2: return 32'(m_count[sel]);
      default: return 32'(m_pend[sel]);
    endcase
  endfunction

  function automatic logic model_intrp();
    for (int c = 0; c < NCH; c++)
      if (m_pend[c] != 0 && m_im[c] != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void model_step(input logic we, input logic [31:0] a, input logic [31:0] d);
    int sel;
    int rg;
    bit prev_fire;
    bit tick[NCH];
    bit fire[NCH];
    sel = int'(a[6:4]);
    rg  = int'(a[3:2]);
    prev_fire = 1'b0;
    // First decide which channels tick, from the pre-edge state.
    for (int c = 0; c < NCH; c++) begin
      bit hit;
      bit running;
      bit src;
      hit     = we && (sel == c);
      running = (m_en[c] != 0) && (m_mode[c] < 2);
      if (CASC_ON && c > 0 && m_casc[c] != 0) src = prev_fire;
      else src = (m_phase[c] % (m_ps[c] + 1)) == m_ps[c];
      tick[c] = running && src && !hit;
      fire[c] = tick[c] && (m_count[c] == 1);
      prev_fire = fire[c];
    end
    // Then apply the state changes.
    for (int c = 0; c < NCH; c++) begin
      bit hit;
      hit = we && (sel == c);
      if ((hit && rg == 0) || m_en[c] == 0) m_phase[c] = 0;
      else if (m_mode[c] < 2) m_phase[c]++;
      if (tick[c]) begin
        if (m_count[c] > 1) m_count[c]--;
        else if (m_count[c] == 1) begin
          m_count[c] = 0;
          if (m_mode[c] == 0) m_en[c] = 0;
        end else m_count[c] = m_preset[c];
      end
      if (hit) begin
        case (rg)
          0: begin
            m_en[c]   = int'(d[0]);
            m_mode[c] = int'(d[2:1]);
            m_im[c]   = int'(d[3]);
            m_casc[c] = (CASC_ON && c > 0) ? int'(d[4]) : 0;
            m_ps[c]   = int'(d[8 +: PSW]);
          end
          1: m_preset[c] = int'(d & CW_MASK);
          2: ;
          default: if (d[0]) m_pend[c] = 0;
        endcase
      end
      if (fire[c]) m_pend[c] = 1;
    end
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called at a negedge: drive, compare pre-edge outputs, step model at posedge.
  task automatic cycle(input logic we, input logic [31:0] a, input logic [31:0] d);
    DEV_WE = we; DEV_Addr = a; DEV_WD = d;
    #1;
    check("rd", DEV_RD, model_read(a));
    check("intrp", {31'b0, intrp}, {31'b0, model_intrp()});
    @(posedge clk);
    if (reset) model_step(we, a, d);
    @(negedge clk);
    DEV_WE = 1'b0;
  endtask

  task automatic expect_now(input string tag, input logic [31:0] a, input logic [31:0] exp);
    DEV_WE = 1'b0; DEV_Addr = a;
    #1;
    check(tag, DEV_RD, exp);
  endtask

  task automatic idle(input int n, input logic [31:0] a);
    for (int i = 0; i < n; i++) cycle(1'b0, a, 32'h0);
  endtask

  // Assert reset mid-activity, check everything reads cleared, release.
  task automatic do_reset();
    reset = 1'b0;
    model_reset();
    for (int k = 0; k < 12; k++) begin
      logic [31:0] a;
      a = 32'(k * 4);
      expect_now("rst_rd", a, (k < 4 * NCH) ? 32'h0 : 32'h6666_6666);
    end
    check("rst_intrp", {31'b0, intrp}, 32'h0);
    idle(2, 32'h08);
    reset = 1'b1;
  endtask

  logic [31:0] exp_os [6] = '{32'd0, 32'd3, 32'd2, 32'd1, 32'd0, 32'd0};
  logic [31:0] exp_ps [9] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd1, 32'd1, 32'd1, 32'd1, 32'd0};

  initial begin
    n_cmp = 0; n_err = 0;
    reset = 1'b0; DEV_WE = 1'b0; DEV_Addr = '0; DEV_WD = '0;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // Start counting on ch0, then reset in the middle of it.
    cycle(1'b1, 32'h04, 32'd5);
    cycle(1'b1, 32'h00, 32'h0B);
    idle(3, 32'h08);
    do_reset();
    idle(8, 32'h08);   // no activity until EN is written

    // One-shot on ch0.
    cycle(1'b1, 32'h04, 32'd3);
    cycle(1'b1, 32'h00, 32'h9);
    for (int i = 0; i < 6; i++) begin
      expect_now("os_count", 32'h08, exp_os[i]);
      cycle(1'b0, 32'h08, 32'h0);
    end
    expect_now("os_ctrl", 32'h00, 32'h8);
    check("os_intrp", {31'b0, intrp}, 32'h1);
    expect_now("os_pend", 32'h0C, 32'h1);
    cycle(1'b1, 32'h0C, 32'h1);
    check("os_clr_intrp", {31'b0, intrp}, 32'h0);

    // Auto-reload on ch1 with STATUS clears at every phase of the period.
    cycle(1'b1, 32'h14, 32'd2);
    cycle(1'b1, 32'h10, 32'hB);
    idle(6, 32'h1C);
    for (int k = 0; k < 6; k++) begin
      idle(k % 3, 32'h18);
      cycle(1'b1, 32'h1C, 32'h1);
      cycle(1'b0, 32'h1C, 32'h0);
    end
    cycle(1'b1, 32'h10, 32'h0);
    cycle(1'b1, 32'h1C, 32'h1);

    // Prescaler PS=3 on ch0, then a CTRL rewrite restarts the phase.
    cycle(1'b1, 32'h04, 32'd1);
    cycle(1'b1, 32'h00, 32'h30B);
    for (int i = 0; i < 9; i++) begin
      expect_now("ps_count", 32'h08, exp_ps[i]);
      cycle(1'b0, 32'h08, 32'h0);
    end
    idle(3, 32'h08);
    cycle(1'b1, 32'h00, 32'h30B);
    idle(10, 32'h08);
    cycle(1'b1, 32'h00, 32'h0);
    cycle(1'b1, 32'h0C, 32'h1);

    // Out-of-range channel, and masked pending interrupt.
    expect_now("bad_rd", 32'h20, 32'h6666_6666);
    cycle(1'b1, 32'h20, 32'hFFFF_FFFF);
    cycle(1'b1, 32'h24, 32'hFFFF_FFFF);
    idle(1, 32'h00);
    idle(1, 32'h10);
    cycle(1'b1, 32'h10, 32'h3);
    idle(8, 32'h18);
    expect_now("im_pend", 32'h1C, 32'h1);
    check("im_mask", {31'b0, intrp}, 32'h0);
    cycle(1'b1, 32'h10, 32'h0);
    cycle(1'b1, 32'h1C, 32'h1);

`ifdef TIMCOU_CASCADE_EN
    do_reset();
    cycle(1'b1, 32'h04, 32'd1);
    cycle(1'b1, 32'h14, 32'd2);
    cycle(1'b1, 32'h10, 32'h1B);
    cycle(1'b1, 32'h00, 32'h3);
    for (int i = 0; i < 40; i++) cycle(1'b0, (i % 2) ? 32'h18 : 32'h1C, 32'h0);
    expect_now("casc_ctrl1", 32'h10, 32'h1B);
`endif

    // Randomised traffic.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] a;
      logic [31:0] d;
      a = 32'(($urandom_range(0, 2) << 4) | ($urandom_range(0, 3) << 2));
      d = $urandom;
      if ($urandom_range(0, 5) == 0) begin
        case (a[3:2])
          2'd0: begin
            d[0]    = ($urandom_range(0, 4) != 0);
            d[2:1]  = ($urandom_range(0, 7) < 6) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3));
            d[11:8] = 4'($urandom_range(0, 3));
          end
          2'd1: if ($urandom_range(0, 19) != 0) d = $urandom_range(0, 6);
          default: ;
        endcase
        cycle(1'b1, a, d);
      end else begin
        cycle(1'b0, a, d);
      end
    end

    // Reset mid-traffic leaves everything idle.
    do_reset();
    idle(6, 32'h08);
    idle(6, 32'h18);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
